reaction_timer_core: RTL and testbench
======================================

Name: reaction_timer_core

Overview:
- Parametrised multi-round reaction-time engine: successor to the single-shot start/react tester.
- Takes raw start/react buttons and generates an LFSR-randomised wait. Measures reaction in ms ticks and detects false starts.
- Runs ROUNDS rounds and reports each score plus a session average.
- Sits between the tile-level pin wrapper and the 7-segment display mux; it drives LED and binary score only, not segments.

Parameters:
- TICK_DIV, 10000, clk cycles per 1 ms tick (10 MHz clock).
- MIN_DELAY_MS, 1000, fixed part of the pre-GO wait, in ms.
- RAND_BITS, 11, width of the random wait added to MIN_DELAY_MS (0..2^RAND_BITS-1 ms).
- ROUNDS, 4, rounds per session; must be a power of two, from 1 to 16.
- MAX_MS, 9999, saturation and timeout value for a score.
- SCORE_W, 14, score width; must hold MAX_MS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start_btn  in  1  raw, asynchronous start button
- react_btn  in  1  raw, asynchronous react button
- led_go  out  1  high while in GO
- state_o  out  3  encoded FSM state
- round_o  out  4  current round index, 0-based
- score_o  out  SCORE_W  last latched score, or the session average in DONE
- score_vld  out  1  one-cycle pulse when score_o updates
- false_start  out  1  high while in FALSE state
- best_o  out  SCORE_W  best (minimum) score of the session; see Optional Feature

Behaviour:
- Interface: one clock clk; rst_n is asynchronous assert, active-low. All flops reset to zero, except the LFSR seed, which resets to 1.
- Reset outputs:
  - led_go=0, state_o=IDLE(0), round_o=0, score_o=0, score_vld=0, false_start=0.
  - best_o = all ones with BEST_TRACK_EN defined; 0 without it.
- Inputs: each button passes through a 2-flop synchroniser, then a rising-edge detector. A press is a 1-cycle pulse, 3 clk after the pin edge.
- Tick: a free-running counter 0..TICK_DIV-1 pulses tick for one cycle at wrap. The counter is cleared on every state entry.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clk in every state.
- States and encodings: IDLE=0, WAIT=1, GO=2, RESULT=3, FALSE=4, DONE=5.
- IDLE:
  - start press -> WAIT.
  - On entry to WAIT: delay counter loaded with MIN_DELAY_MS + lfsr[RAND_BITS-1:0]; sum cleared; round_o=0.
- WAIT:
  - Delay counter decrements on tick.
  - react press (priority over all else) -> FALSE.
  - Delay counter reaches 0 on a tick -> GO; ms counter cleared.
- GO:
  - led_go=1; ms counter increments on tick.
  - react press -> RESULT. Latch score_o = ms count and pulse score_vld. sum += score.
  - If ms count reaches MAX_MS with no press -> RESULT with score MAX_MS (timeout).
  - react press and MAX_MS on the same cycle -> record MAX_MS.
- RESULT, on start press:
  - round_o < ROUNDS-1 -> round_o++, enter WAIT with a fresh random delay.
  - round_o == ROUNDS-1 -> DONE. score_o = sum >> log2(ROUNDS); pulse score_vld.
- FALSE:
  - false_start=1. The round is not counted and round_o is unchanged.
  - start press -> WAIT with a fresh random delay.
- DONE: score_o holds the average. start press -> IDLE; round_o, sum and best are cleared.
- Buttons in states that ignore them: start in WAIT/GO is ignored; react in IDLE/RESULT/FALSE/DONE is ignored. Start and react pressed on the same cycle: only the button relevant to the current state acts.
- Sum width: SCORE_W + 4 bits, so the sum cannot overflow at ROUNDS=16.
- Reset mid-session: immediate return to IDLE with all reset values; no partial results are kept.

Optional Feature:
- Macro: BEST_TRACK_EN.
- Defined: best_o updates on each counted score when the score is below the current best; timeouts count. best_o resets to all ones and is cleared to all ones on DONE->IDLE.
- Undefined: best_o tied to 0; no comparator or register is synthesised.

Decomposition:
- Shared package:
  - state enum and encodings.
  - LFSR polynomial/tap constant and the reset seed.
  - clog2-based derived widths, for example log2(ROUNDS).
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse, instantiated once per button.

Test Plan:
Bench parameters: TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2, ROUNDS=2, MAX_MS=20.
- Reset then idle 50 clk -> all outputs at reset values; state_o=0.
- start press; react held off until led_go rises; react pressed 7 ticks later -> score_o=7 with a single score_vld pulse; state_o=3.
- react pressed during WAIT -> false_start=1, state_o=4, round_o=0. Then start -> WAIT again; the later round still reports round_o=0.
- No react in GO -> after 20 ticks state_o=3, score_o=20.
- Two rounds scoring 7 and 12 -> DONE with score_o=9 (19>>1). With BEST_TRACK_EN, best_o=7.
- rst_n asserted during GO -> led_go drops asynchronously; after release state_o=0, score_o=0.

Source files
------------

// File: rtl/reaction_timer_core_pkg.sv
// Shared definitions for the reaction timer: FSM encodings, LFSR polynomial/seed
// and width helpers used by the core.
package reaction_timer_core_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_GO     = 3'd2;
  localparam state_t ST_RESULT = 3'd3;
  localparam state_t ST_FALSE  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_timer_core_btn_sync.sv
// Button conditioner: 2-flop synchroniser followed by a rising-edge detector that
// yields a single-cycle press pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], btn_i};
    end
  end

  // sync_q[2] only acts as the edge-detector history, not as a third sync stage
  assign press_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/reaction_timer_core.sv
// Multi-round reaction-time engine: random wait, ms scoring, false-start detection
// and session average. Define BEST_TRACK_EN to enable best-score tracking on best_o.
module reaction_timer_core
  import reaction_timer_core_pkg::*;
#(
  parameter int TICK_DIV     = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int ROUNDS       = 4,
  parameter int MAX_MS       = 9999,
  parameter int SCORE_W      = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               react_btn,
  output logic               led_go,
  output logic [2:0]         state_o,
  output logic [3:0]         round_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               score_vld,
  output logic               false_start,
  output logic [SCORE_W-1:0] best_o
);

  localparam int TICK_W  = clog2_min1(TICK_DIV);
  localparam int DELAY_W = clog2_min1(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam int SUM_W   = SCORE_W + 4;
  localparam int AVG_SH  = $clog2(ROUNDS);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]         ROUND_LAST = 4'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_MS);
  localparam logic [DELAY_W-1:0] DELAY_MIN  = DELAY_W'(MIN_DELAY_MS);

  logic               start_press, react_press;
  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [SCORE_W-1:0] ms_q, ms_d;
  logic [3:0]         round_q, round_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               vld_q, vld_d;
  logic               tick, timeout;
  logic [SCORE_W-1:0] capped;
  logic [DELAY_W-1:0] delay_seed;

  btn_sync_edge u_start (.clk(clk), .rst_n(rst_n), .btn_i(start_btn), .press_o(start_press));
  btn_sync_edge u_react (.clk(clk), .rst_n(rst_n), .btn_i(react_btn), .press_o(react_press));

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign timeout    = (ms_q >= SCORE_MAX);
  assign capped     = timeout ? SCORE_MAX : ms_q;
  assign delay_seed = DELAY_MIN + DELAY_W'(lfsr_q[RAND_BITS-1:0]);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_next(lfsr_q);
    delay_d = delay_q;
    ms_d    = ms_q;
    round_d = round_q;
    sum_d   = sum_q;
    score_d = score_q;
    vld_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d = ST_WAIT;
          delay_d = delay_seed;
          sum_d   = '0;
          round_d = '0;
        end
      end
      ST_WAIT: begin
        if (react_press) begin
          state_d = ST_FALSE;
        end else if (tick) begin
          if (delay_q <= DELAY_W'(1)) begin
            state_d = ST_GO;
            ms_d    = '0;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end
      end
      ST_GO: begin
        if (react_press || timeout) begin
          state_d = ST_RESULT;
          score_d = capped;
          vld_d   = 1'b1;
          sum_d   = sum_q + SUM_W'(capped);
        end else if (tick) begin
          ms_d = ms_q + SCORE_W'(1);
        end
      end
      ST_RESULT: begin
        if (start_press) begin
          if (round_q < ROUND_LAST) begin
            state_d = ST_WAIT;
            round_d = round_q + 4'd1;
            delay_d = delay_seed;
          end else begin
            state_d = ST_DONE;
            score_d = SCORE_W'(sum_q >> AVG_SH);
            vld_d   = 1'b1;
          end
        end
      end
      ST_FALSE: begin
        if (start_press) begin
          state_d = ST_WAIT;
          delay_d = delay_seed;
        end
      end
      ST_DONE: begin
        if (start_press) begin
          state_d = ST_IDLE;
          round_d = '0;
          sum_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state entry restarts the ms tick phase so each interval is whole ticks
    tick_cnt_d = ((state_d != state_q) || tick) ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      delay_q    <= '0;
      ms_q       <= '0;
      round_q    <= '0;
      sum_q      <= '0;
      score_q    <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      delay_q    <= delay_d;
      ms_q       <= ms_d;
      round_q    <= round_d;
      sum_q      <= sum_d;
      score_q    <= score_d;
      vld_q      <= vld_d;
    end
  end

`ifdef BEST_TRACK_EN
  logic [SCORE_W-1:0] best_q;
  logic               counted;

  assign counted = (state_q == ST_GO) && (react_press || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '1;
    end else if ((state_q == ST_DONE) && start_press) begin
      best_q <= '1;
    end else if (counted && (capped < best_q)) begin
      best_q <= capped;
    end
  end

  assign best_o = best_q;
`else
  assign best_o = '0;
`endif

  assign led_go      = (state_q == ST_GO);
  assign false_start = (state_q == ST_FALSE);
  assign state_o     = state_q;
  assign round_o     = round_q;
  assign score_o     = score_q;
  assign score_vld   = vld_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed, table-driven bench for reaction_timer_core with small timing parameters.
module tb_reaction_timer_core;

  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] ONES = '1;
`ifdef BEST_TRACK_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  localparam int OP_IDLE        = 0;
  localparam int OP_START       = 1;
  localparam int OP_REACT       = 2;
  localparam int OP_WAITGO      = 3;
  localparam int OP_REACT_TICKS = 4;

  typedef struct {
    int                 op;
    int                 arg;
    logic [2:0]         expState;
    logic               expLed;
    logic               expFalse;
    logic [3:0]         expRound;
    bit                 chkScore;
    logic [SCORE_W-1:0] expScore;
    int                 expVld;
    logic [SCORE_W-1:0] expBest;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_btn = 1'b0;
  logic               react_btn = 1'b0;
  logic               led_go;
  logic [2:0]         state_o;
  logic [3:0]         round_o;
  logic [SCORE_W-1:0] score_o;
  logic               score_vld;
  logic               false_start;
  logic [SCORE_W-1:0] best_o;

  int   checks = 0;
  int   errors = 0;
  int   vldCount = 0;
  vec_t vecs[17];

  reaction_timer_core #(
    .TICK_DIV(4), .MIN_DELAY_MS(2), .RAND_BITS(2), .ROUNDS(2), .MAX_MS(20), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .react_btn(react_btn),
    .led_go(led_go), .state_o(state_o), .round_o(round_o), .score_o(score_o),
    .score_vld(score_vld), .false_start(false_start), .best_o(best_o)
  );

  always #5 clk = ~clk;

  // Counts score_vld cycles so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (score_vld === 1'b1) vldCount++;
  end

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic pressBtn(input bit isReact);
    repeat (2) @(negedge clk);
    if (isReact) react_btn = 1'b1;
    else start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    react_btn = 1'b0;
  endtask

  task automatic waitGo(input string name);
    int n = 0;
    while (led_go !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no led_go within %0d cycles expected led_go=1", name, n);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    case (v.op)
      OP_IDLE:   repeat (v.arg) @(negedge clk);
      OP_START:  pressBtn(1'b0);
      OP_REACT:  pressBtn(1'b1);
      OP_WAITGO: waitGo($sformatf("step%0d go", idx));
      OP_REACT_TICKS: begin
        repeat (4 * v.arg) @(negedge clk);
        react_btn = 1'b1;
        repeat (3) @(negedge clk);
        react_btn = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [SCORE_W-1:0] eb;
    #1;
    eb = BEST_ON ? v.expBest : '0;
    checkVal($sformatf("step%0d state", idx), int'(state_o), int'(v.expState));
    checkVal($sformatf("step%0d led_go", idx), int'(led_go), int'(v.expLed));
    checkVal($sformatf("step%0d false_start", idx), int'(false_start), int'(v.expFalse));
    checkVal($sformatf("step%0d round", idx), int'(round_o), int'(v.expRound));
    if (v.chkScore) checkVal($sformatf("step%0d score", idx), int'(score_o), int'(v.expScore));
    checkVal($sformatf("step%0d vld_pulses", idx), vldCount, v.expVld);
    checkVal($sformatf("step%0d best", idx), int'(best_o), int'(eb));
  endtask

  initial begin
    //           op              arg st    led   fs    rnd   chk  score   vld best
    vecs[0]  = '{OP_IDLE,        50, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 14'd0,  0, ONES};
    vecs[1]  = '{OP_REACT,        0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 14'd0,  0, ONES};
    vecs[2]  = '{OP_START,        0, 3'd1, 1'b0, 1'b0, 4'd0, 1'b1, 14'd0,  0, ONES};
    vecs[3]  = '{OP_REACT,        0, 3'd4, 1'b0, 1'b1, 4'd0, 1'b1, 14'd0,  0, ONES};
    vecs[4]  = '{OP_START,        0, 3'd1, 1'b0, 1'b0, 4'd0, 1'b1, 14'd0,  0, ONES};
    vecs[5]  = '{OP_WAITGO,       0, 3'd2, 1'b1, 1'b0, 4'd0, 1'b1, 14'd0,  0, ONES};
    vecs[6]  = '{OP_REACT_TICKS,  7, 3'd3, 1'b0, 1'b0, 4'd0, 1'b1, 14'd7,  1, 14'd7};
    vecs[7]  = '{OP_REACT,        0, 3'd3, 1'b0, 1'b0, 4'd0, 1'b1, 14'd7,  1, 14'd7};
    vecs[8]  = '{OP_START,        0, 3'd1, 1'b0, 1'b0, 4'd1, 1'b1, 14'd7,  1, 14'd7};
    vecs[9]  = '{OP_WAITGO,       0, 3'd2, 1'b1, 1'b0, 4'd1, 1'b1, 14'd7,  1, 14'd7};
    vecs[10] = '{OP_REACT_TICKS, 12, 3'd3, 1'b0, 1'b0, 4'd1, 1'b1, 14'd12, 2, 14'd7};
    vecs[11] = '{OP_START,        0, 3'd5, 1'b0, 1'b0, 4'd1, 1'b1, 14'd9,  3, 14'd7};
    vecs[12] = '{OP_REACT,        0, 3'd5, 1'b0, 1'b0, 4'd1, 1'b1, 14'd9,  3, 14'd7};
    vecs[13] = '{OP_START,        0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 14'd0,  3, ONES};
    vecs[14] = '{OP_START,        0, 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 14'd0,  3, ONES};
    vecs[15] = '{OP_WAITGO,       0, 3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 14'd0,  3, ONES};
    vecs[16] = '{OP_IDLE,        85, 3'd3, 1'b0, 1'b0, 4'd0, 1'b1, 14'd20, 4, 14'd20};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(vecs[i], i);
    end

    // Second round of the session, then reset in the middle of GO
    pressBtn(1'b0);
    #1;
    checkVal("rst_seq wait state", int'(state_o), 1);
    checkVal("rst_seq wait round", int'(round_o), 1);
    waitGo("rst_seq go");
    repeat (10) @(negedge clk);
    #1;
    checkVal("rst_seq led before reset", int'(led_go), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("async reset led_go", int'(led_go), 0);
    checkVal("async reset state", int'(state_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkVal("post reset state", int'(state_o), 0);
    checkVal("post reset score", int'(score_o), 0);
    checkVal("post reset round", int'(round_o), 0);
    checkVal("post reset score_vld", int'(score_vld), 0);
    checkVal("post reset false_start", int'(false_start), 0);
    checkVal("post reset best", int'(best_o), BEST_ON ? int'(ONES) : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
